// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port word memory between the fetch (I)
// and load/store (D) requesters. One access per three cycles; acks and read data are registered.
module mem_arbiter #(
  parameter int WORD_SIZE = 32,
  parameter int ADDR_W    = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_req,
  input  logic [ADDR_W-1:0]    i_addr,
  output logic                 i_ack,
  output logic [WORD_SIZE-1:0] i_rdata,
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [ADDR_W-1:0]    d_addr,
  input  logic [WORD_SIZE-1:0] d_wdata,
  output logic                 d_ack,
  output logic [WORD_SIZE-1:0] d_rdata,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic                 mem_write,
  output logic [WORD_SIZE-1:0] mem_data_in,
  input  logic [WORD_SIZE-1:0] mem_data_out,
  output logic                 busy
);

  typedef enum logic [1:0] {IDLE, ACC_I, ACC_D, RESP} state_t;

  state_t                 state_q, state_d;
  logic                   last_d_q, last_d_d;   // 1: D held the most recent grant
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [WORD_SIZE-1:0]   wdata_q, wdata_d;
  logic                   we_q, we_d;
  logic                   i_ack_q, i_ack_d, d_ack_q, d_ack_d;
  logic [WORD_SIZE-1:0]   i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
  logic                   grant_i, grant_d;

  // I wins when alone or when D was served last; D takes whatever I does not.
  assign grant_i = i_req && (!d_req || last_d_q);
  assign grant_d = d_req && !grant_i;

  always_comb begin
    state_d   = state_q;
    last_d_d  = last_d_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = we_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    i_ack_d   = 1'b0;
    d_ack_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (grant_i) begin
          addr_d   = i_addr;
          last_d_d = 1'b0;
          state_d  = ACC_I;
        end else if (grant_d) begin
          addr_d   = d_addr;
          we_d     = d_we;
          wdata_d  = d_wdata;
          last_d_d = 1'b1;
          state_d  = ACC_D;
        end
      end
      ACC_I: begin
        i_rdata_d = mem_data_out;
        i_ack_d   = 1'b1;
        state_d   = RESP;
      end
      ACC_D: begin
        if (!we_q) d_rdata_d = mem_data_out;
        d_ack_d = 1'b1;
        state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      last_d_q  <= 1'b1;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      i_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      last_d_q  <= last_d_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      i_ack_q   <= i_ack_d;
      d_ack_q   <= d_ack_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  // Write enable decodes from state so a reset during ACC_D kills it immediately.
  assign mem_write   = (state_q == ACC_D) && we_q;
  assign mem_addr    = addr_q;
  assign mem_data_in = wdata_q;
  assign busy        = (state_q != IDLE);
  assign i_ack       = i_ack_q;
  assign d_ack       = d_ack_q;
  assign i_rdata     = i_rdata_q;
  assign d_rdata     = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural single-port memory
// preloaded so that mem[k] = 0x11111111 * (k + 1).
module tb_mem_arbiter;
  localparam int W  = 32;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [AW-1:0] i_addr = '0, d_addr = '0;
  logic [W-1:0]  d_wdata = '0;
  logic          i_ack, d_ack, mem_write, busy;
  logic [W-1:0]  i_rdata, d_rdata, mem_data_in, mem_data_out;
  logic [AW-1:0] mem_addr;
  logic          pre_n = 1'b0;
  logic [W-1:0]  mem [256];

  int errs   = 0;
  int checks = 0;

  mem_arbiter #(.WORD_SIZE(W), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_write(mem_write), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!pre_n) begin
      for (int k = 0; k < 256; k++) mem[k] <= 32'(32'h1111_1111 * (k + 1));
    end else if (mem_write) begin
      mem[mem_addr] <= mem_data_in;
    end
  end
  assign mem_data_out = mem[mem_addr];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One D access from IDLE; checks latency, write-enable width and ack pulse width.
  task automatic d_access(input logic we, input logic [AW-1:0] a, input logic [W-1:0] wd,
                          input string tag);
    int n = 0;
    int wcnt = 0;
    bit got = 0;
    d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd;
    while (!got && n < 10) begin
      tick();
      n++;
      if (mem_write) wcnt++;
      if (d_ack) got = 1;
    end
    d_req = 1'b0;
    chk({tag, "_ack_latency"}, 64'(n), 64'd2);
    chk({tag, "_write_cycles"}, 64'(wcnt), we ? 64'd1 : 64'd0);
    tick();
    chk({tag, "_ack_pulse"}, 64'(d_ack), 64'd0);
  endtask

  task automatic do_reset();
    i_req = 1'b0; d_req = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    int n, wcnt;
    bit got, both;
    logic [15:0] ia, da;

    // reset state
    tick();
    pre_n = 1'b1;
    tick();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_iack", 64'(i_ack), 64'd0);
    chk("rst_dack", 64'(d_ack), 64'd0);
    chk("rst_irdata", 64'(i_rdata), 64'd0);
    chk("rst_drdata", 64'(d_rdata), 64'd0);
    chk("rst_mwrite", 64'(mem_write), 64'd0);
    chk("rst_maddr", 64'(mem_addr), 64'd0);
    chk("rst_mdin", 64'(mem_data_in), 64'd0);
    rst_n = 1'b1;
    tick();

    // single fetch
    i_req = 1'b1; i_addr = 8'd1;
    n = 0; wcnt = 0; got = 0;
    while (!got && n < 10) begin
      tick();
      n++;
      if (mem_write) wcnt++;
      if (n == 1) chk("f_busy_acc", 64'(busy), 64'd1);
      if (i_ack) got = 1;
    end
    i_req = 1'b0;
    chk("f_latency", 64'(n), 64'd2);
    chk("f_rdata", 64'(i_rdata), 64'h2222_2222);
    chk("f_nowrite", 64'(wcnt), 64'd0);
    tick();
    chk("f_ack_pulse", 64'(i_ack), 64'd0);
    chk("f_idle", 64'(busy), 64'd0);

    // store then load
    d_access(1'b1, 8'd5, 32'hDEAD_BEEF, "st5");
    chk("st5_mem", 64'(mem[5]), 64'hDEAD_BEEF);
    d_access(1'b0, 8'd5, 32'h0, "ld5");
    chk("ld5_rdata", 64'(d_rdata), 64'hDEAD_BEEF);

    // contention from reset release: I first, then alternate, 3 cycles apart
    do_reset();
    i_req = 1'b1; i_addr = 8'd1;
    d_req = 1'b1; d_we = 1'b0; d_addr = 8'd5;
    ia = '0; da = '0; both = 0;
    for (int t = 1; t <= 12; t++) begin
      tick();
      if (i_ack) ia[t] = 1'b1;
      if (d_ack) da[t] = 1'b1;
      if (i_ack && d_ack) both = 1;
    end
    i_req = 1'b0; d_req = 1'b0;
    chk("ct_iack_cycles", 64'(ia), 64'h0104);
    chk("ct_dack_cycles", 64'(da), 64'h0820);
    chk("ct_never_both", 64'(both), 64'd0);
    chk("ct_irdata", 64'(i_rdata), 64'h2222_2222);
    chk("ct_drdata", 64'(d_rdata), 64'hDEAD_BEEF);
    tick();

    // inputs changed after grant are ignored
    d_req = 1'b1; d_we = 1'b1; d_addr = 8'd5; d_wdata = 32'h1234_5678;
    tick();
    chk("ig_maddr", 64'(mem_addr), 64'd5);
    chk("ig_mwrite", 64'(mem_write), 64'd1);
    d_addr = 8'd7; d_wdata = 32'hBAD0_BAD0;
    tick();
    d_req = 1'b0;
    chk("ig_ack", 64'(d_ack), 64'd1);
    chk("ig_mem5", 64'(mem[5]), 64'h1234_5678);
    chk("ig_mem7", 64'(mem[7]), 64'h8888_8888);
    tick();

    // reset during a store
    d_req = 1'b1; d_we = 1'b1; d_addr = 8'd9; d_wdata = 32'hCAFE_F00D;
    tick();
    chk("rm_mwrite_pre", 64'(mem_write), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rm_mwrite_async", 64'(mem_write), 64'd0);
    d_req = 1'b0;
    tick();
    chk("rm_mem9", 64'(mem[9]), 64'hAAAA_AAAA);
    chk("rm_dack", 64'(d_ack), 64'd0);
    chk("rm_busy", 64'(busy), 64'd0);
    chk("rm_maddr", 64'(mem_addr), 64'd0);
    chk("rm_mdin", 64'(mem_data_in), 64'd0);
    chk("rm_drdata", 64'(d_rdata), 64'd0);
    chk("rm_irdata", 64'(i_rdata), 64'd0);
    rst_n = 1'b1;
    tick();
    chk("rm_dack_after", 64'(d_ack), 64'd0);
    chk("rm_busy_after", 64'(busy), 64'd0);

    // idle hold after a load
    d_access(1'b0, 8'd5, 32'h0, "ld5b");
    for (int t = 0; t < 10; t++) begin
      tick();
      chk("ih_busy", 64'(busy), 64'd0);
    end
    chk("ih_drdata", 64'(d_rdata), 64'h1234_5678);
    chk("ih_maddr", 64'(mem_addr), 64'd5);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
